// File: rtl/an_encoder_awe_clk_if.sv
// rtl/an_encoder_awe_clk_if.sv - handshake bundle between the AN-code encoder and its neighbours
//
// Groups the input-word handshake, the codeword handshake and, when ERR_INJ_EN
// is defined, the per-word error-injection controls.
//   in_valid/in_ready/N_in     : data word N offered to the encoder
//   out_valid/out_ready/W      : codeword W = A*N (+E) delivered downstream
//   inj_en/inj_neg/inj_pos     : +/-2^inj_pos arithmetic error (ERR_INJ_EN only)
// Modport master = the side that supplies words and consumes codewords;
// modport slave = the encoder.
interface an_encoder_awe_clk_if #(
    parameter int N_BITS = 31,
    parameter int W_BITS = 38
) ();
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] N_in;
    logic              out_valid;
    logic              out_ready;
    logic [W_BITS-1:0] W;
`ifdef ERR_INJ_EN
    logic              inj_en;
    logic              inj_neg;
    logic [5:0]        inj_pos;
`endif

    modport master (
        output in_valid,
        output N_in,
        output out_ready,
`ifdef ERR_INJ_EN
        output inj_en,
        output inj_neg,
        output inj_pos,
`endif
        input  in_ready,
        input  out_valid,
        input  W
    );

    modport slave (
        input  in_valid,
        input  N_in,
        input  out_ready,
`ifdef ERR_INJ_EN
        input  inj_en,
        input  inj_neg,
        input  inj_pos,
`endif
        output in_ready,
        output out_valid,
        output W
    );
endinterface

// File: rtl/an_encoder_awe_clk.sv
// rtl/an_encoder_awe_clk.sv - sequential shift-add AN-code encoder, W = A*N (+E) mod 2^W_BITS
//
// One multiplier bit of A is consumed per cycle, so a word spends A_BITS cycles
// in MUL after being accepted. Optional feature macro: ERR_INJ_EN adds a single
// arithmetic error +/-2^inj_pos to the codeword, latched with the word.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : an_encoder_awe_clk_if.slave (word in, codeword out, injection controls)
module an_encoder_awe_clk #(
    parameter int A      = 83,
    parameter int A_BITS = 7,
    parameter int N_BITS = 31,
    parameter int W_BITS = 38
) (
    input  logic                 clk,
    input  logic                 rst,
    an_encoder_awe_clk_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [A_BITS-1:0] A_VEC  = A_BITS'(A);
    localparam logic [A_BITS-1:0] I_ONE  = A_BITS'(1);
    localparam logic [A_BITS-1:0] I_LAST = A_BITS'(A_BITS - 1);
    localparam logic [W_BITS-1:0] W_ONE  = W_BITS'(1);

    state_t             state;
    logic [W_BITS-1:0]  acc;
    logic [W_BITS-1:0]  mcand;
    logic [A_BITS-1:0]  i;
    logic [A_BITS-1:0]  a_shift;
    logic               a_bit;
    logic [W_BITS-1:0]  next_acc;
    logic [W_BITS-1:0]  inj_term;

    // Current multiplier bit A[i], taken by shifting so the index width needs no trimming.
    assign a_shift  = A_VEC >> i;
    assign a_bit    = a_shift[0];
    assign next_acc = a_bit ? (acc + (mcand << i)) : acc;

`ifdef ERR_INJ_EN
    logic [W_BITS-1:0] inj_mag;

    // Positions at or beyond W_BITS would shift out entirely; treat them as no error.
    always_comb begin
        inj_mag  = '0;
        inj_term = '0;
        if (bus.inj_en && (int'(bus.inj_pos) < W_BITS)) begin
            inj_mag  = W_ONE << bus.inj_pos;
            inj_term = bus.inj_neg ? (~inj_mag + W_ONE) : inj_mag;
        end
    end
`else
    assign inj_term = '0;
`endif

    assign bus.in_ready = (state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            acc           <= '0;
            mcand         <= '0;
            i             <= '0;
            bus.out_valid <= 1'b0;
            bus.W         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        mcand <= {{(W_BITS - N_BITS){1'b0}}, bus.N_in};
                        // Preloading the error term means the multiply needs no extra add cycle.
                        acc   <= inj_term;
                        i     <= '0;
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc <= next_acc;
                    if (i == I_LAST) begin
                        bus.W         <= next_acc;
                        bus.out_valid <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        i <= i + I_ONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_an_encoder_awe_clk.sv
// tb/tb_an_encoder_awe_clk.sv - scoreboard bench for the AN-code encoder
module tb_an_encoder_awe_clk;

    logic clk;
    logic rst;

    an_encoder_awe_clk_if #(.N_BITS(31), .W_BITS(38)) bus ();

    an_encoder_awe_clk #(
        .A      (83),
        .A_BITS (7),
        .N_BITS (31),
        .W_BITS (38)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pushed = 0;
    int popped = 0;
    logic [37:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a transfer is committed on the next rising edge whenever both
    // out_valid and out_ready are high at the falling edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got W=%0d expected no output", bus.W);
            end else begin
                check("W", 64'(bus.W), 64'(exp_q.pop_front()));
                popped++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one word; optionally measure cycles from accept to out_valid.
    task automatic send(input logic [30:0] n, input logic [37:0] exp, input bit track);
        int k;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            tick();
            k++;
        end
        check("accept_ready", 64'(bus.in_ready), 64'd1);
        exp_q.push_back(exp);
        pushed++;
        bus.N_in     = n;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.N_in     = 31'h2AAA_AAAA;
`ifdef ERR_INJ_EN
        bus.inj_en  = 1'b1;
        bus.inj_neg = 1'b1;
        bus.inj_pos = 6'd3;
`endif
        if (track) begin
            k = 0;
            while (!bus.out_valid && k < 20) begin
                tick();
                k++;
            end
            check("latency", 64'(k), 64'd7);
        end
    endtask

`ifdef ERR_INJ_EN
    task automatic set_inj(input logic en, input logic neg, input logic [5:0] pos);
        bus.inj_en  = en;
        bus.inj_neg = neg;
        bus.inj_pos = pos;
    endtask
`endif

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.N_in      = '0;
        bus.out_ready = 1'b1;
`ifdef ERR_INJ_EN
        set_inj(1'b0, 1'b0, 6'd0);
`endif
        repeat (3) tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_W", 64'(bus.W), 64'd0);
        rst = 1'b0;
        tick();

        // N=1: latency 7, one-cycle pulse with out_ready held high.
        send(31'd1, 38'd83, 1'b1);
        tick();
        check("pulse_width", 64'(bus.out_valid), 64'd0);
        check("ready_after_xfer", 64'(bus.in_ready), 64'd1);

        // Largest word, then zero.
        send(31'h7FFF_FFFF, 38'd178241142701, 1'b1);
        tick();
        send(31'd0, 38'd0, 1'b1);
        tick();

        // Backpressure: hold for 5 cycles after out_valid rises.
        bus.out_ready = 1'b0;
        send(31'd12345, 38'd1024635, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_W", 64'(bus.W), 64'd1024635);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("ready_after_hold", 64'(bus.in_ready), 64'd1);
        check("valid_after_hold", 64'(bus.out_valid), 64'd0);

`ifdef ERR_INJ_EN
        set_inj(1'b1, 1'b0, 6'd7);
        send(31'd5, 38'd543, 1'b1);
        tick();
        set_inj(1'b1, 1'b1, 6'd0);
        send(31'd0, 38'h3F_FFFF_FFFF, 1'b1);
        tick();
        set_inj(1'b1, 1'b1, 6'd40);
        send(31'd0, 38'd0, 1'b1);
        tick();
        set_inj(1'b0, 1'b0, 6'd0);
        send(31'd7, 38'd581, 1'b1);
        tick();
        set_inj(1'b0, 1'b0, 6'd0);
`endif

        // Reset mid-MUL: N=9 is discarded (no expectation pushed).
        bus.N_in     = 31'd9;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
`ifdef ERR_INJ_EN
        set_inj(1'b0, 1'b0, 6'd0);
`endif
        repeat (3) tick();
        check("mid_mul_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("async_rst_ready", 64'(bus.in_ready), 64'd1);
        check("async_rst_valid", 64'(bus.out_valid), 64'd0);
        tick();
        rst = 1'b0;
        send(31'd2, 38'd166, 1'b1);
        tick();
        repeat (12) tick();

        check("outputs_seen", 64'(popped), 64'(pushed));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
